// File: rtl/mdu.sv
// mdu: multiply/divide unit for the execute stage.
//   Runs mult/multu/div/divu as multi-cycle operations and holds the
//   architectural HI/LO registers. mthi/mtlo write HI/LO directly.
//   The result is computed when Start is accepted and parked in tmp_hi/tmp_lo.
//   It is committed to HI/LO when the down-counter reaches zero.
//
// Parameters:
//   MULT_CYCLES  cycles Busy stays high for mult/multu (>=1)
//   DIV_CYCLES   cycles Busy stays high for div/divu (>=1)
//
// Ports:
//   clk     system clock, rising edge
//   reset   asynchronous, active-high; clears all state
//   A, B    forwarded operands rs / rt
//   MDUOp   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   Start   one-cycle strobe: the execute-stage instruction is an MDU op
//   Cancel  (only with MDU_CANCEL_EN) flushes any in-flight op and this
//           cycle's Start
//   Busy    multi-cycle operation in flight
//   HI, LO  architectural HI/LO
//
// Optional feature: define MDU_CANCEL_EN to add the Cancel input.

module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDUOp,
  input  logic        Start,
`ifdef MDU_CANCEL_EN
  input  logic        Cancel,
`endif
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [CW-1:0] cnt;
  logic [31:0]   tmp_hi, tmp_lo;
  logic          commit_en;  // cleared for divide-by-zero so HI/LO stay put

  // Products
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'b0, A} * {32'b0, B};

  // Signed division via magnitudes. This keeps 0x80000000 / -1 well defined:
  // the magnitude quotient 0x80000000 keeps its sign bit after the sign fix-up.
  logic [31:0] a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic        b_zero;
  assign b_zero = (B == 32'd0);
  assign a_mag  = A[31] ? (~A + 32'd1) : A;
  assign b_mag  = B[31] ? (~B + 32'd1) : B;
  assign q_mag  = b_zero ? 32'd0 : (a_mag / b_mag);
  assign r_mag  = b_zero ? 32'd0 : (a_mag % b_mag);
  assign q_s    = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s    = A[31] ? (~r_mag + 32'd1) : r_mag;
  assign q_u    = b_zero ? 32'd0 : (A / B);
  assign r_u    = b_zero ? 32'd0 : (A % B);

  assign Busy = (cnt != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      tmp_hi    <= '0;
      tmp_lo    <= '0;
      commit_en <= 1'b0;
      HI        <= '0;
      LO        <= '0;
    end else begin
`ifdef MDU_CANCEL_EN
      if (Cancel) begin
        cnt       <= '0;
        tmp_hi    <= '0;
        tmp_lo    <= '0;
        commit_en <= 1'b0;
      end else
`endif
      if (cnt != '0) begin
        // Start while busy is ignored entirely.
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1) && commit_en) begin
          HI <= tmp_hi;
          LO <= tmp_lo;
        end
      end else if (Start) begin
        unique case (MDUOp)
          OP_MULT: begin
            {tmp_hi, tmp_lo} <= prod_s;
            commit_en        <= 1'b1;
            cnt              <= CW'(MULT_CYCLES);
          end
          OP_MULTU: begin
            {tmp_hi, tmp_lo} <= prod_u;
            commit_en        <= 1'b1;
            cnt              <= CW'(MULT_CYCLES);
          end
          OP_DIV: begin
            tmp_lo    <= q_s;
            tmp_hi    <= r_s;
            commit_en <= ~b_zero;
            cnt       <= CW'(DIV_CYCLES);
          end
          OP_DIVU: begin
            tmp_lo    <= q_u;
            tmp_hi    <= r_u;
            commit_en <= ~b_zero;
            cnt       <= CW'(DIV_CYCLES);
          end
          OP_MTHI: HI <= A;
          OP_MTLO: LO <= A;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] A = '0, B = '0;
  logic [2:0]  MDUOp = '0;
  logic        Start = 1'b0;
`ifdef MDU_CANCEL_EN
  logic        Cancel = 1'b0;
`endif
  logic        Busy;
  logic [31:0] HI, LO;

  int errors = 0;
  int checks = 0;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDUOp(MDUOp), .Start(Start),
`ifdef MDU_CANCEL_EN
    .Cancel(Cancel),
`endif
    .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Behavioural model: time-based. An accepted op started at edge k finishes at
  // edge k+N; Busy is expected after edge e iff e < m_done.
  longint      ecnt = 0;
  longint      m_done = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit          m_commit = 0;

  always @(posedge clk) begin
    longint sa, sb, q, r;
    longint unsigned ua, ub, pu;
    logic [63:0] p;
    bit cancel_now;
    ecnt++;
    cancel_now = 0;
`ifdef MDU_CANCEL_EN
    cancel_now = Cancel;
`endif
    if (reset) begin
      m_hi = '0; m_lo = '0; m_done = 0; m_commit = 0;
    end else if (cancel_now) begin
      if (m_done > ecnt - 1) m_done = ecnt - 1;
      m_commit = 0;
    end else begin
      if (ecnt == m_done && m_commit) begin
        m_hi = p_hi; m_lo = p_lo;
      end
      if (Start && (ecnt - 1 >= m_done)) begin
        sa = longint'($signed(A));
        sb = longint'($signed(B));
        ua = longint'(A);
        ub = longint'(B);
        case (MDUOp)
          3'd1: begin p = sa * sb; {p_hi, p_lo} = p; m_commit = 1; m_done = ecnt + MC; end
          3'd2: begin pu = ua * ub; {p_hi, p_lo} = pu; m_commit = 1; m_done = ecnt + MC; end
          3'd3: begin
            m_commit = (B != 0);
            if (B != 0) begin q = sa / sb; r = sa % sb; p_lo = q[31:0]; p_hi = r[31:0]; end
            m_done = ecnt + DC;
          end
          3'd4: begin
            m_commit = (B != 0);
            if (B != 0) begin p_lo = 32'(ua / ub); p_hi = 32'(ua % ub); end
            m_done = ecnt + DC;
          end
          3'd5: m_hi = A;
          3'd6: m_lo = A;
          default: ;
        endcase
      end
    end
    #1;
    chk("model_busy", {31'b0, Busy}, {31'b0, (ecnt < m_done)});
    chk("model_hi", HI, m_hi);
    chk("model_lo", LO, m_lo);
  end

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    A = a; B = b; MDUOp = op; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; MDUOp = 3'd0;
    A = $urandom; B = $urandom;  // operands must have been sampled already
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (Busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      errors++; checks++;
      $display("FAIL busy_timeout: Busy still high after %0d cycles", n);
    end
  endtask

  int n;

  initial begin
    #1;
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    do_op(3'd1, 32'hFFFFFFFF, 32'h00000002);
    count_busy(n);
    chk("mult_busy_cycles", n, MC);
    chk("mult_hi", HI, 32'hFFFFFFFF);
    chk("mult_lo", LO, 32'hFFFFFFFE);

    do_op(3'd2, 32'hFFFFFFFF, 32'h00000002);
    count_busy(n);
    chk("multu_busy_cycles", n, MC);
    chk("multu_hi", HI, 32'h00000001);
    chk("multu_lo", LO, 32'hFFFFFFFE);

    do_op(3'd3, 32'hFFFFFFF9, 32'h00000002);
    count_busy(n);
    chk("div_busy_cycles", n, DC);
    chk("div_lo", LO, 32'hFFFFFFFD);
    chk("div_hi", HI, 32'hFFFFFFFF);

    do_op(3'd4, 32'd7, 32'd0);
    count_busy(n);
    chk("divz_busy_cycles", n, DC);
    chk("divz_hi", HI, 32'hFFFFFFFF);
    chk("divz_lo", LO, 32'hFFFFFFFD);

    @(negedge clk);
    A = 32'h12345678; MDUOp = 3'd5; Start = 1'b1;
    @(negedge clk);
    chk("mthi_hi", HI, 32'h12345678);
    chk("mthi_busy", {31'b0, Busy}, 32'd0);
    A = 32'h9ABCDEF0; MDUOp = 3'd6;
    @(negedge clk);
    Start = 1'b0; MDUOp = 3'd0;
    chk("mtlo_lo", LO, 32'h9ABCDEF0);
    chk("mtlo_busy", {31'b0, Busy}, 32'd0);

    do_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
    count_busy(n);
    chk("divovf_lo", LO, 32'h80000000);
    chk("divovf_hi", HI, 32'h00000000);

    do_op(3'd4, 32'd100, 32'd7);
    count_busy(n);
    chk("divu_lo", LO, 32'd14);
    chk("divu_hi", HI, 32'd2);

    // Start ignored while busy: divu issued on the 3rd busy cycle.
    do_op(3'd1, 32'd3, 32'd5);
    @(negedge clk);
    @(negedge clk);
    A = 32'd1; B = 32'd1; MDUOp = 3'd4; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; MDUOp = 3'd0;
    count_busy(n);
    chk("overlap_busy_rest", n, MC - 3);
    chk("overlap_hi", HI, 32'd0);
    chk("overlap_lo", LO, 32'd15);
    @(negedge clk);
    chk("overlap_no_restart", {31'b0, Busy}, 32'd0);

    // Asynchronous reset on the 4th busy cycle of a div.
    do_op(3'd3, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", {31'b0, Busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_busy", {31'b0, Busy}, 32'd0);
    chk("async_rst_hi", HI, 32'd0);
    chk("async_rst_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (DC + 2) @(negedge clk);
    chk("post_rst_busy", {31'b0, Busy}, 32'd0);
    chk("post_rst_hi", HI, 32'd0);
    chk("post_rst_lo", LO, 32'd0);

`ifdef MDU_CANCEL_EN
    do_op(3'd5, 32'hAAAA0001, 32'd0);
    do_op(3'd6, 32'h5555000F, 32'd0);
    do_op(3'd1, 32'h00010000, 32'h00010000);
    @(negedge clk);
    Cancel = 1'b1;
    @(negedge clk);
    Cancel = 1'b0;
    chk("cancel_busy", {31'b0, Busy}, 32'd0);
    chk("cancel_hi", HI, 32'hAAAA0001);
    chk("cancel_lo", LO, 32'h5555000F);
    repeat (MC + 1) @(negedge clk);
    chk("cancel_no_commit_hi", HI, 32'hAAAA0001);
    @(negedge clk);
    A = 32'hDEADBEEF; MDUOp = 3'd5; Start = 1'b1; Cancel = 1'b1;
    @(negedge clk);
    Start = 1'b0; Cancel = 1'b0; MDUOp = 3'd0;
    chk("cancel_mthi_hi", HI, 32'hAAAA0001);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
